// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and width limit for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle between producer and serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_busy;
  modport master (output i_valid, i_a, i_b, i_ready, input o_ready, o_valid, o_sum, o_carry, o_busy);
  modport slave  (input i_valid, i_a, i_b, i_ready, output o_ready, o_valid, o_sum, o_carry, o_busy);
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit full adder built from two half adders
module half_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_bit1 ^ i_bit2;
  assign o_carry = i_bit1 & i_bit2;
endmodule

module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  logic s0, c0, c1;
  half_adder u_ha0 (.i_bit1(i_bit1), .i_bit2(i_bit2), .o_sum(s0), .o_carry(c0));
  half_adder u_ha1 (.i_bit1(s0), .i_bit2(i_carry), .o_sum(o_sum), .o_carry(c1));
  assign o_carry = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per cycle through a single full adder
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          i_clk,
  input logic          i_rst,
  serial_adder_if.slave bus
);
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d, cout_q, cout_d;
  logic               s, c_next;
  full_adder u_fa (.i_bit1(a_q[0]), .i_bit2(b_q[0]), .i_carry(c_q), .o_sum(s), .o_carry(c_next));
  // next-state: latch on accept, shift one bit per BUSY edge, hold result in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        state_d = BUSY;
        a_d     = bus.i_a;
        b_d     = bus.i_b;
        res_d   = '0;
        cnt_d   = '0;
        c_d     = 1'b0;
      end
      BUSY: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        cnt_d = cnt_q + CNT_W'(1);
        c_d   = c_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cout_d  = c_next;
        end
      end
      DONE: state_d = bus.i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset clears everything so nothing depends on X
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end
  assign bus.o_ready = state_q == IDLE;
  assign bus.o_busy  = state_q == BUSY;
  assign bus.o_valid = state_q == DONE;
  assign bus.o_sum   = res_q;
  assign bus.o_carry = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against A+B
module tb_serial_adder;
  localparam int W = 8;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  always #5 i_clk = ~i_clk;
  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 1);
    check({tag, "_valid"}, 32'(bus.o_valid), 0);
    check({tag, "_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_sum"}, 32'(bus.o_sum), 0);
    check({tag, "_carry"}, 32'(bus.o_carry), 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit pulse);
    int cyc;
    logic [W:0] e;
    e = {1'b0, a} + {1'b0, b};
    bus.i_ready = 1'b0;
    cyc = 0;
    while (!bus.o_ready && cyc < 50) begin
      tick;
      cyc++;
    end
    check("ready_before", 32'(bus.o_ready), 1);
    bus.i_valid = 1'b1;
    bus.i_a = a;
    bus.i_b = b;
    tick;
    bus.i_valid = 1'b0;
    bus.i_a = W'($urandom);
    bus.i_b = W'($urandom);
    check("busy", 32'(bus.o_busy), 1);
    check("ready_busy", 32'(bus.o_ready), 0);
    cyc = 0;
    while (!bus.o_valid && cyc < 50) begin
      tick;
      cyc++;
    end
    check("latency", 32'(cyc), W);
    check("sum", 32'(bus.o_sum), 32'(e[W-1:0]));
    check("carry", 32'(bus.o_carry), 32'(e[W]));
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = pulse && (i == 1);
      bus.i_a = 8'h99;
      bus.i_b = 8'h99;
      tick;
      check("hold_valid", 32'(bus.o_valid), 1);
      check("hold_sum", 32'(bus.o_sum), 32'(e[W-1:0]));
      check("hold_carry", 32'(bus.o_carry), 32'(e[W]));
      check("hold_ready", 32'(bus.o_ready), 0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick;
    bus.i_ready = 1'b0;
    check("valid_drop", 32'(bus.o_valid), 0);
    check("ready_back", 32'(bus.o_ready), 1);
    if (hold > 0) begin
      for (int i = 0; i < W + 4; i++) begin
        bus.i_ready = 1'b1;
        tick;
        check("no_extra", 32'(bus.o_valid | bus.o_busy), 0);
      end
      bus.i_ready = 1'b0;
    end
  endtask

  initial begin
    int n_acc, n_res, cyc, last;
    logic [W-1:0] qa[$], qb[$];
    logic [W-1:0] a, b;
    logic [W:0] e;
    logic acc, fire;
    bus.i_valid = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_ready = 1'b0;
    tick;
    tick;
    i_rst = 1'b0;
    check_idle("reset");
    do_op(8'h00, 8'h00, 0, 1'b0);
    do_op(8'h0F, 8'h01, 0, 1'b0);
    do_op(8'hA5, 8'h5A, 0, 1'b0);
    do_op(8'hFF, 8'h01, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 0, 1'b0);
    do_op(8'h12, 8'h34, 5, 1'b1);
    bus.i_valid = 1'b1;
    bus.i_a = 8'hC3;
    bus.i_b = 8'h3C;
    tick;
    bus.i_valid = 1'b0;
    tick;
    tick;
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    check_idle("midrst");
    do_op(8'h80, 8'h80, 0, 1'b0);
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    last = 0;
    while ((n_acc < 200 || n_res < n_acc) && cyc < 20000) begin
      a = W'($urandom);
      b = W'($urandom);
      bus.i_valid = n_acc < 200;
      bus.i_a = a;
      bus.i_b = b;
      bus.i_ready = 1'($urandom_range(0, 1));
      acc = bus.i_valid && bus.o_ready;
      fire = bus.o_valid && bus.i_ready;
      if (fire) begin
        if (qa.size() == 0) check("spurious_valid", 32'(bus.o_valid), 0);
        else begin
          e = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()};
          check("rnd_sum", 32'(bus.o_sum), 32'(e[W-1:0]));
          check("rnd_carry", 32'(bus.o_carry), 32'(e[W]));
          n_res++;
        end
      end
      tick;
      cyc++;
      if (acc) begin
        if (n_acc > 0) check("spacing", 32'((cyc - last) >= W + 2), 1);
        last = cyc;
        qa.push_back(a);
        qb.push_back(b);
        n_acc++;
      end
    end
    bus.i_valid = 1'b0;
    check("rnd_accepts", 32'(n_acc), 200);
    check("rnd_results", 32'(n_res), 32'(n_acc));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder for two WIDTH-bit unsigned operands.
- Each cycle, one bit position passes through a single full-adder cell built from two half_adder instances; the carry is held in a register between cycles.
- Valid/ready handshakes on both the operand side and the result side.
- Used where adder area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
i_clk  input  1  clock, rising-edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  operands present on i_a/i_b.
o_ready  output  1  block can accept operands (high only in IDLE).
i_a  input  WIDTH  operand A, unsigned.
i_b  input  WIDTH  operand B, unsigned.
o_valid  output  1  result present on o_sum/o_carry.
i_ready  input  1  downstream accepts the result.
o_sum  output  WIDTH  (A+B) mod 2^WIDTH.
o_carry  output  1  carry out of bit WIDTH-1.
o_busy  output  1  high while in BUSY.

Behaviour:
- Single clock, i_clk. Reset i_rst is synchronous and active-high, sampled on the rising edge of i_clk.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0, carry reg=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY:
  - Occurs on an edge where i_valid && o_ready (the accept edge E0).
  - i_a/i_b are latched into shift regs A_sh/B_sh.
  - Carry reg and counter are cleared to 0; result reg is cleared.
- BUSY, each edge:
  - s = A_sh[0]^B_sh[0]^c and c_next = majority(A_sh[0], B_sh[0], c), both via full_adder.
  - A_sh and B_sh shift right by 1.
  - s shifts into the result reg MSB, with the result reg shifting right.
  - Counter increments.
- BUSY -> DONE: on the edge where counter==WIDTH-1, i.e. after exactly WIDTH BUSY edges (E1..E_WIDTH).
  - The final sum bit is written and o_carry<=c_next on that same edge.
- Latency: o_valid goes high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accept edge.
- DONE:
  - o_valid=1; o_sum/o_carry are the final values and held stable while i_ready=0, for any number of cycles.
  - DONE -> IDLE on an edge with i_ready=1.
  - o_sum/o_carry keep their last values in IDLE; only o_valid defines their meaning.
- o_ready=1 only in IDLE.
  - i_valid asserted in BUSY/DONE is ignored and creates no queueing.
  - i_a/i_b may change freely after E0.
- No same-edge DONE->accept. Minimum spacing between accepts is WIDTH+2 cycles.
- Wrap-around: the sum truncates to WIDTH bits and the overflow appears only on o_carry.
- Reset mid-operation (BUSY or DONE): the operation is abandoned with no result emitted. All outputs take their reset values on the next cycle.
- i_rst has priority over every handshake on the same edge.
- WIDTH=1: BUSY lasts one edge, and o_valid rises one cycle after accept.
- Internal regs are not X-dependent: A_sh, B_sh and result are reset as well.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE};
  - localparam MAX_WIDTH = 32.
- Sub-module full_adder (i_bit1, i_bit2, i_carry -> o_sum, o_carry):
  - Two half_adder instances plus an OR of their carries.
  - Purely combinational; instantiated once inside serial_adder.
- The top level holds the FSM, shift registers, counter and carry register.

Test Plan (WIDTH=8):
1. i_a=0x00, i_b=0x00, i_ready=1 -> o_valid exactly 8 cycles after accept; o_sum=0x00, o_carry=0; o_valid high 1 cycle, o_ready returns to 1 the next cycle.
2. i_a=0x0F, i_b=0x01 -> o_sum=0x10, o_carry=0 (carry ripple across 4 bits). i_a=0xA5, i_b=0x5A -> o_sum=0xFF, o_carry=0.
3. i_a=0xFF, i_b=0x01 -> o_sum=0x00, o_carry=1. i_a=0xFF, i_b=0xFF -> o_sum=0xFE, o_carry=1.
4. Backpressure on 0x12+0x34:
   - Hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1 and o_sum=0x46 stays stable; o_ready=0.
   - i_valid pulsed with 0x99+0x99 during this window -> ignored.
   - Then raise i_ready -> IDLE, and no second result appears.
5. Reset mid-operation:
   - Accept 0xC3+0x3C and assert i_rst on the 3rd BUSY edge -> next cycle o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0.
   - Then 0x80+0x80 -> o_sum=0x00, o_carry=1, with no leftover carry or bit state.
6. Back-to-back random: 200 operand pairs with i_valid always high and i_ready randomized -> every result matches the {carry,sum} = A+B scoreboard; accepts are spaced ≥10 cycles apart; result count equals accept count.
